// File: rtl/sccb_cam_config.sv
// sccb_cam_config
//   Configures the OV7670 camera over SCCB after reset. Walks a fixed table of
//   register writes and timed delays, then raises done. A start pulse while
//   done re-runs the table (no startup wait).
//
//   Optional feature macro: SCCB_ACK_CHECK_EN
//     defined   - sda_in is sampled on the first cycle of q2 of every 9th bit;
//                 a 1 sets the sticky cfg_err flag.
//     undefined - sda_in is unused, cfg_err is tied 0.
//
//   Ports
//     clk, rst_n : system clock, asynchronous active-low reset
//     ena        : advance enable; low freezes all state and outputs
//     start      : re-run request, honoured only in DONE
//     sda_in     : SDA pin level (synchronised externally)
//     scl        : SCL, push-pull
//     sda_oe     : 1 pulls SDA low, 0 releases it
//     busy, done : sequence in progress / table complete
//     cfg_idx    : current table entry
//     cfg_err    : sticky NACK flag
module sccb_cam_config #(
    parameter int         CLK_QTR        = 62,
    parameter int         STARTUP_CYCLES = 25000,
    parameter int         DELAY_UNIT     = 25000,
    parameter logic [7:0] DEV_ADDR       = 8'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic [2:0] cfg_idx,
    output logic       cfg_err
);
    localparam int NUM_ENTRIES = 6;
    localparam int QW = (CLK_QTR > 1) ? $clog2(CLK_QTR) : 1;

    typedef enum logic [2:0] {
        ST_STARTUP, ST_FETCH, ST_START, ST_BIT, ST_STOP, ST_GAP, ST_WAIT, ST_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] qcnt;       // cycle within the current quarter
    logic [1:0]    qtr;        // quarter within a bit or a 2-quarter phase
    logic [1:0]    byte_sel;   // 0 device address, 1 register address, 2 data
    logic [3:0]    bit_pos;    // 0..7 data bits MSB first, 8 = released 9th bit
    logic [31:0]   dly_cnt;
    logic [7:0]    ent_addr, ent_data, cur_byte;
    logic [31:0]   dly_len;
    logic [1:0]    last_q;
    logic          quartered, qtr_end, group_end, last_bit, dly_end;

    // Configuration table; addr FF marks a delay of data x DELAY_UNIT cycles.
    always_comb begin
        ent_addr = 8'h8C;
        ent_data = 8'h00;
        case (cfg_idx)
            3'd0: begin ent_addr = 8'h12; ent_data = 8'h80; end  // soft reset
            3'd1: begin ent_addr = 8'hFF; ent_data = 8'h0A; end  // settle delay
            3'd2: begin ent_addr = 8'h12; ent_data = 8'h14; end  // QVGA RGB
            3'd3: begin ent_addr = 8'h40; ent_data = 8'hD0; end  // RGB565 full range
            3'd4: begin ent_addr = 8'h11; ent_data = 8'h01; end  // CLKRC
            default: begin ent_addr = 8'h8C; ent_data = 8'h00; end
        endcase
    end

    always_comb begin
        case (byte_sel)
            2'd0:    cur_byte = DEV_ADDR;
            2'd1:    cur_byte = ent_addr;
            default: cur_byte = ent_data;
        endcase
    end

    assign quartered = (state == ST_START) || (state == ST_BIT) ||
                       (state == ST_STOP)  || (state == ST_GAP);
    assign qtr_end   = quartered && (qcnt == QW'(CLK_QTR - 1));
    assign last_q    = (state == ST_BIT) ? 2'd3 : 2'd1;
    // Last cycle of a bit (4 quarters) or of a START/STOP/GAP phase (2 quarters).
    assign group_end = qtr_end && (qtr == last_q);
    assign last_bit  = (byte_sel == 2'd2) && (bit_pos == 4'd8);
    assign dly_len   = (state == ST_STARTUP) ? 32'(STARTUP_CYCLES)
                                             : 32'(ent_data) * 32'(DELAY_UNIT);
    // A zero-length delay still spends its single WAIT cycle.
    assign dly_end   = (dly_len == 32'd0) || (dly_cnt == dly_len - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state <= ST_STARTUP;
        else if (ena) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scl       = 1'b1;
        sda_oe    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_STARTUP: if (dly_end) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (cfg_idx == 3'(NUM_ENTRIES)) state_nxt = ST_DONE;
                else if (ent_addr == 8'hFF)     state_nxt = ST_WAIT;
                else                            state_nxt = ST_START;
            end
            ST_START: begin
                // q0 bus idle, q1 SDA low with SCL high
                sda_oe = qtr[0];
                if (group_end) state_nxt = ST_BIT;
            end
            ST_BIT: begin
                // SCL low for q0/q1, high for q2/q3; SDA set from q0 so it
                // only moves while SCL is low.
                scl    = qtr[1];
                sda_oe = (bit_pos == 4'd8) ? 1'b0 : ~cur_byte[3'd7 - bit_pos[2:0]];
                if (group_end && last_bit) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // SDA low with SCL high, then release SDA
                sda_oe = ~qtr[0];
                if (group_end) state_nxt = ST_GAP;
            end
            ST_GAP:  if (group_end) state_nxt = ST_FETCH;
            ST_WAIT: if (dly_end) state_nxt = ST_FETCH;
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt     <= '0;
            qtr      <= '0;
            byte_sel <= '0;
            bit_pos  <= '0;
            dly_cnt  <= '0;
            cfg_idx  <= '0;
        end else if (ena) begin
            qcnt <= (quartered && !qtr_end) ? qcnt + 1'b1 : '0;

            if (!quartered)   qtr <= '0;
            else if (qtr_end) qtr <= (qtr == last_q) ? 2'd0 : qtr + 2'd1;

            if (state != ST_BIT) begin
                byte_sel <= '0;
                bit_pos  <= '0;
            end else if (group_end) begin
                if (bit_pos == 4'd8) begin
                    bit_pos  <= '0;
                    byte_sel <= last_bit ? 2'd0 : byte_sel + 2'd1;
                end else begin
                    bit_pos  <= bit_pos + 4'd1;
                end
            end

            dly_cnt <= ((state == ST_STARTUP || state == ST_WAIT) && !dly_end)
                       ? dly_cnt + 32'd1 : 32'd0;

            if (state == ST_DONE && start)
                cfg_idx <= '0;
            else if ((state == ST_GAP && group_end) || (state == ST_WAIT && dly_end))
                cfg_idx <= cfg_idx + 3'd1;
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else if (ena) begin
            if (state == ST_DONE && start)
                cfg_err <= 1'b0;
            else if (state == ST_BIT && bit_pos == 4'd8 && qtr == 2'd2 && qcnt == '0 && sda_in)
                cfg_err <= 1'b1;
        end
    end
`else
    logic sda_in_unused;
    assign sda_in_unused = sda_in;
    assign cfg_err       = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_cam_config.sv
// Bench for sccb_cam_config. Cycle numbering: cycle 0 is the first clock
// period after rst_n is released; cyc counts rising edges since then.
module tb_sccb_cam_config;
    localparam int QTR = 2;
    localparam int SU  = 10;
    localparam int DU  = 4;
    localparam int NE  = 6;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0, sda_in = 1'b0;
    logic       scl, sda_oe, busy, done, cfg_err;
    logic [2:0] cfg_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    sccb_cam_config #(
        .CLK_QTR(QTR), .STARTUP_CYCLES(SU), .DELAY_UNIT(DU), .DEV_ADDR(8'h42)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sda_in(sda_in),
        .scl(scl), .sda_oe(sda_oe), .busy(busy), .done(done),
        .cfg_idx(cfg_idx), .cfg_err(cfg_err)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- reference model (plain arithmetic over the table) ----
    function automatic logic [15:0] tbl(input int i);
        case (i)
            0: return 16'h1280;
            1: return 16'hFF0A;
            2: return 16'h1214;
            3: return 16'h40D0;
            4: return 16'h1101;
            default: return 16'h8C00;
        endcase
    endfunction

    // Cycles from the first FETCH to done rising (final FETCH included).
    function automatic int exp_run_len();
        int t = 0;
        logic [15:0] e;
        for (int i = 0; i < NE; i++) begin
            e = tbl(i);
            t += 1;
            if (e[15:8] == 8'hFF) t += int'(e[7:0]) * DU;
            else                  t += 114 * QTR;
        end
        return t + 1;
    endfunction

    // Offset from the first FETCH to the START SDA-low of write frame k.
    function automatic int exp_frame_off(input int k);
        int t = 0;
        int n = 0;
        logic [15:0] e;
        for (int i = 0; i < NE; i++) begin
            e = tbl(i);
            t += 1;
            if (e[15:8] == 8'hFF) t += int'(e[7:0]) * DU;
            else begin
                if (n == k) return t + QTR;
                n++;
                t += 114 * QTR;
            end
        end
        return -1;
    endfunction

    function automatic logic [23:0] exp_frame(input int k);
        int n = 0;
        logic [15:0] e;
        for (int i = 0; i < NE; i++) begin
            e = tbl(i);
            if (e[15:8] != 8'hFF) begin
                if (n == k) return {8'h42, e};
                n++;
            end
        end
        return 24'h0;
    endfunction

    // ---------------- bus monitor: decodes frames from the pins ------------
    logic        p_scl = 1'b1, p_oe = 1'b0;
    bit          bus_busy = 1'b0;
    int          bits = 0;
    int          viol = 0;
    logic [26:0] sh = '0;
    logic [23:0] frames_q[$];
    int          starts_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            bus_busy = 1'b0;
            bits     = 0;
            p_scl    = 1'b1;
            p_oe     = 1'b0;
        end else begin
            if (p_scl && scl && sda_oe != p_oe) begin
                if (sda_oe && !bus_busy) begin
                    bus_busy = 1'b1;
                    bits     = 0;
                    starts_q.push_back(cyc);
                end else if (!sda_oe && bus_busy && bits == 27) begin
                    bus_busy = 1'b0;
                end else if (!(bus_busy && bits == 27)) begin
                    viol++;
                end
            end
            if (!p_scl && scl && bus_busy && bits < 27) begin
                sh = {sh[25:0], ~sda_oe};
                bits++;
                if (bits == 27) frames_q.push_back({sh[26:19], sh[17:10], sh[8:1]});
            end
            p_scl = scl;
            p_oe  = sda_oe;
        end
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic do_release();
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs until done is seen (done_at = cycle) or the budget expires (-1).
    // ack_frame >= 0 drives a NACK in the first 9th bit of that frame.
    task automatic drive_run(input int start_at, input int st_from, input int st_len,
                             input int ack_frame, output int done_at);
        int base, b;
        base    = frames_q.size();
        done_at = -1;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (done) begin
                done_at = cyc;
                break;
            end
            start = (cyc == start_at);
            ena   = !(cyc >= st_from && cyc < st_from + st_len);
            b     = bits;
            if (ack_frame >= 0 && frames_q.size() - base == ack_frame && bus_busy && (b == 8 || b == 9))
                sda_in = 1'b1;
            else if (b == 8 || b == 9 || b == 17 || b == 18 || b == 26 || b == 27)
                sda_in = 1'b0;
            else
                sda_in = 1'($urandom);
        end
        start  = 1'b0;
        ena    = 1'b1;
        sda_in = 1'b0;
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        int first = -1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({scl, sda_oe, busy, done, cfg_idx, cfg_err} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got scl=%b oe=%b busy=%b done=%b idx=%0d err=%b want 1 0 1 0 0 0",
                     scl, sda_oe, busy, done, cfg_idx, cfg_err);
        end
        do_release();
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (cyc < SU) begin
                total++;
                if (!(busy && scl && !sda_oe && !done)) begin
                    bad++;
                    $display("FAIL startup_idle cyc=%0d: got scl=%b oe=%b busy=%b done=%b want 1 0 1 0",
                             cyc, scl, sda_oe, busy, done);
                end
            end
            if (sda_oe && first < 0) first = cyc;
        end
        total++;
        if (first != SU + exp_frame_off(0)) begin
            bad++;
            $display("FAIL first_sda_low: got cycle %0d want %0d", first, SU + exp_frame_off(0));
        end
    endtask

    task automatic test_sequence();
        int d, bf, bs, v0;
        do_release();
        bf = frames_q.size();
        bs = starts_q.size();
        v0 = viol;
        drive_run(-1, -1, 0, -1, d);
        total++;
        if (d != SU + exp_run_len()) begin
            bad++;
            $display("FAIL seq_done_cycle: got %0d want %0d", d, SU + exp_run_len());
        end
        total++;
        if (busy !== 1'b0 || cfg_idx !== 3'(NE)) begin
            bad++;
            $display("FAIL seq_done_state: got busy=%b idx=%0d want 0 %0d", busy, cfg_idx, NE);
        end
        total++;
        if (frames_q.size() - bf != 5) begin
            bad++;
            $display("FAIL seq_frame_count: got %0d want 5", frames_q.size() - bf);
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (frames_q[bf + k] !== exp_frame(k)) begin
                    bad++;
                    $display("FAIL seq_frame%0d: got %h want %h", k, frames_q[bf + k], exp_frame(k));
                end
                total++;
                if (starts_q[bs + k] != SU + exp_frame_off(k)) begin
                    bad++;
                    $display("FAIL seq_start%0d: got cycle %0d want %0d", k, starts_q[bs + k], SU + exp_frame_off(k));
                end
            end
        end
        total++;
        if (viol != v0) begin
            bad++;
            $display("FAIL sda_while_scl_high: got %0d events want 0", viol - v0);
        end
        total++;
        if (cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL seq_cfg_err: got %b want 0", cfg_err);
        end
    endtask

    // Entered with the DUT in DONE.
    task automatic test_restart();
        int d, t0, bf, bs;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        bf = frames_q.size();
        bs = starts_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        total++;
        if ({busy, done, cfg_idx} !== {1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL restart_ack: got busy=%b done=%b idx=%0d want 1 0 0", busy, done, cfg_idx);
        end
        drive_run(-1, -1, 0, -1, d);
        total++;
        if (d - t0 != exp_run_len()) begin
            bad++;
            $display("FAIL restart_done: got +%0d want +%0d", d - t0, exp_run_len());
        end
        total++;
        if (frames_q.size() - bf != 5) begin
            bad++;
            $display("FAIL restart_frame_count: got %0d want 5", frames_q.size() - bf);
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (frames_q[bf + k] !== exp_frame(k)) begin
                    bad++;
                    $display("FAIL restart_frame%0d: got %h want %h", k, frames_q[bf + k], exp_frame(k));
                end
            end
            total++;
            if (starts_q[bs] - t0 != exp_frame_off(0)) begin
                bad++;
                $display("FAIL restart_first_start: got +%0d want +%0d", starts_q[bs] - t0, exp_frame_off(0));
            end
        end
    endtask

    task automatic test_start_ignored();
        int d, r;
        for (int it = 0; it < 2; it++) begin
            r = (it == 0) ? 300 : int'($urandom_range(0, SU + exp_run_len() - 1));
            do_release();
            drive_run(r, -1, 0, -1, d);
            total++;
            if (d != SU + exp_run_len()) begin
                bad++;
                $display("FAIL start_ignored@%0d: got done %0d want %0d", r, d, SU + exp_run_len());
            end
        end
    endtask

    task automatic test_reset_mid();
        int d, r, bf;
        for (int it = 0; it < 2; it++) begin
            r = (it == 0) ? 150 : int'($urandom_range(SU + 1, SU + exp_run_len() - 2));
            do_release();
            for (int n = 0; n < 3000 && cyc < r; n++) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            total++;
            if ({scl, sda_oe, busy, done, cfg_idx} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0}) begin
                bad++;
                $display("FAIL reset_abort@%0d: got scl=%b oe=%b busy=%b done=%b idx=%0d want 1 0 1 0 0",
                         r, scl, sda_oe, busy, done, cfg_idx);
            end
            do_release();
            bf = frames_q.size();
            drive_run(-1, -1, 0, -1, d);
            total++;
            if (d != SU + exp_run_len() || frames_q.size() - bf != 5) begin
                bad++;
                $display("FAIL reset_replay@%0d: got done %0d frames %0d want %0d 5",
                         r, d, frames_q.size() - bf, SU + exp_run_len());
            end
        end
    endtask

    task automatic test_ena_stall();
        int d = -1;
        logic [7:0] snap, now;
        do_release();
        snap = '0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (done) begin
                d = cyc;
                break;
            end
            ena = !(cyc >= 500 && cyc < 550);
            now = {scl, sda_oe, busy, done, cfg_idx, cfg_err};
            if (cyc == 500) snap = now;
            if (cyc > 500 && cyc <= 550) begin
                total++;
                if (now !== snap) begin
                    bad++;
                    $display("FAIL ena_freeze cyc=%0d: got %b want %b", cyc, now, snap);
                end
            end
        end
        ena = 1'b1;
        total++;
        if (d != SU + exp_run_len() + 50) begin
            bad++;
            $display("FAIL ena_done: got %0d want %0d", d, SU + exp_run_len() + 50);
        end
    endtask

    task automatic test_random_stall();
        int d, s, l, bf;
        for (int it = 0; it < 3; it++) begin
            s = $urandom_range(0, 1100);
            l = $urandom_range(1, 60);
            do_release();
            bf = frames_q.size();
            drive_run(-1, s, l, -1, d);
            total++;
            if (d != SU + exp_run_len() + l || frames_q.size() - bf != 5) begin
                bad++;
                $display("FAIL rand_stall s=%0d l=%0d: got done %0d frames %0d want %0d 5",
                         s, l, d, frames_q.size() - bf, SU + exp_run_len() + l);
            end
        end
    endtask

    task automatic test_ack_check();
        int d;
        logic exp_err;
`ifdef SCCB_ACK_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_release();
        drive_run(-1, -1, 0, 2, d);
        total++;
        if (d != SU + exp_run_len() || cfg_err !== exp_err) begin
            bad++;
            $display("FAIL ack_nack: got done %0d err %b want %0d %b", d, cfg_err, SU + exp_run_len(), exp_err);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ack_clear_on_start: got err %b busy %b want 0 1", cfg_err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_restart();
        test_start_ignored();
        test_reset_mid();
        test_ena_stall();
        test_random_stall();
        test_ack_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
